// File: rtl/ahb_lite_slave_mem.sv
// AHB-lite word-addressed register memory slave; decodes, waits WAIT_STATES, answers OKAY/ERROR.
// Latency: data phase follows the address phase, stretched by WAIT_STATES Hreadyout-low cycles.
// Backpressure: Hreadyout low during wait and ERR1 cycles; transfers are accepted only on ready cycles.
module ahb_lite_slave_mem #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hsel,
  input  logic [31:0]       Haddr,
  input  logic              Hwrite,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hsize,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Hready,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hreadyout,
  output logic              Hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Pending OKAY data phase (address-phase info held until the ready cycle)
  logic              dp_vld_q;
  logic              dp_wr_q;
  logic [IDX_W-1:0]  dp_idx_q;

  logic              ready_state;
  logic              accept;
  logic              addr_err;
  logic              acc_ok;
  logic              acc_err;
  logic [IDX_W-1:0]  addr_idx;
  logic              dp_done;
  logic              wr_en;
  logic              fwd;

  // Htrans[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
  logic              unused_ok;
  assign unused_ok = Htrans[0];

  // ERR2 is a ready cycle, so a pipelined transfer may be taken there as from IDLE
  assign ready_state = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign accept      = Hsel & Hready & Htrans[1] & ready_state;
  assign addr_err    = (Haddr[1:0] != 2'b00) || (Hsize != 3'b010) ||
                       (Haddr >= 32'(4 * MEM_DEPTH));
  assign acc_ok      = accept & ~addr_err;
  assign acc_err     = accept & addr_err;
  assign addr_idx    = Haddr[IDX_W+1:2];

  // The data phase ends on the edge closing an IDLE (ready) cycle
  assign dp_done     = dp_vld_q & (state_q == S_IDLE);
  assign wr_en       = dp_done & dp_wr_q;
  // A read address phase overlapping a completing write to the same word sees the new data
  assign fwd         = wr_en & (dp_idx_q == addr_idx);

  // State register and wait-state counter
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: counter loads only on accept and stops at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (acc_err) begin
          state_d = S_ERR1;
        end else if (acc_ok && (WAIT_STATES > 0)) begin
          state_d = S_WAIT;
          cnt_d   = 3'(WAIT_STATES);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = S_IDLE;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 1'b0;
    case (state_q)
      S_WAIT: Hreadyout = 1'b0;
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 1'b1;
      end
      S_ERR2: Hresp = 1'b1;
      default: begin
        Hreadyout = 1'b1;
        Hresp     = 1'b0;
      end
    endcase
  end

  // Track the pending data phase; reset drops it so an interrupted write never lands
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_idx_q <= '0;
    end else if (accept) begin
      dp_vld_q <= ~addr_err;
      dp_wr_q  <= Hwrite;
      dp_idx_q <= addr_idx;
    end else if (dp_done) begin
      dp_vld_q <= 1'b0;
    end
  end

  // Memory array, cleared by reset, written when a write data phase completes
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[dp_idx_q] <= Hwdata;
    end
  end

  // Read data captured at accept; memory cannot change before the read's ready cycle
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Hrdata <= '0;
    end else if (acc_ok && !Hwrite) begin
      Hrdata <= fwd ? Hwdata : mem_q[addr_idx];
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench for ahb_lite_slave_mem: three slaves with 0, 2 and 3 wait states.
// Each slave's Hready is looped back from its own Hreadyout.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ahb_lite_slave_mem;

  localparam logic [2:0] S0 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b100;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [2:0] WD = 3'b010;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;
  logic        sel0, sel2, sel3;
  logic [31:0] rd0, rd2, rd3;
  logic        ro0, ro2, ro3;
  logic        rs0, rs2, rs3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Hclk = ~Hclk;

  ahb_lite_slave_mem #(.DATA_W(32), .MEM_DEPTH(16), .WAIT_STATES(0)) u0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel0), .Haddr(Haddr), .Hwrite(Hwrite),
    .Htrans(Htrans), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(ro0),
    .Hrdata(rd0), .Hreadyout(ro0), .Hresp(rs0));

  ahb_lite_slave_mem #(.DATA_W(32), .MEM_DEPTH(16), .WAIT_STATES(2)) u2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel2), .Haddr(Haddr), .Hwrite(Hwrite),
    .Htrans(Htrans), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(ro2),
    .Hrdata(rd2), .Hreadyout(ro2), .Hresp(rs2));

  ahb_lite_slave_mem #(.DATA_W(32), .MEM_DEPTH(16), .WAIT_STATES(3)) u3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel3), .Haddr(Haddr), .Hwrite(Hwrite),
    .Htrans(Htrans), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(ro3),
    .Hrdata(rd3), .Hreadyout(ro3), .Hresp(rs3));

  // One bus cycle: drive address/control of this cycle plus write data of the running data phase
  task automatic step(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                      input logic [1:0] trans, input logic [2:0] size, input logic [31:0] wd);
    @(posedge Hclk);
    #1;
    {sel3, sel2, sel0} = sel;
    Haddr  = addr;
    Hwrite = wr;
    Htrans = trans;
    Hsize  = size;
    Hwdata = wd;
  endtask

  task automatic test_reset;
    Hresetn = 1'b1;
    {sel3, sel2, sel0} = 3'b000;
    Haddr = 32'h0; Hwrite = 1'b0; Htrans = ID; Hsize = WD; Hwdata = 32'h0;
    #1 Hresetn = 1'b0;
    repeat (2) @(negedge Hclk);
    vectors++; if (ro0 !== 1'b1)  begin miscompares++; $display("FAIL rst_ready0: got %b want 1", ro0); end
    vectors++; if (rs0 !== 1'b0)  begin miscompares++; $display("FAIL rst_resp0: got %b want 0", rs0); end
    vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL rst_rdata0: got %h want 0", rd0); end
    vectors++; if (ro3 !== 1'b1)  begin miscompares++; $display("FAIL rst_ready3: got %b want 1", ro3); end
    Hresetn = 1'b1;
    // read 0x04 straight after reset
    step(S0, 32'h04, 1'b0, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL t1_rdata: got %h want 0", rd0); end
    vectors++; if (ro0 !== 1'b1)  begin miscompares++; $display("FAIL t1_ready: got %b want 1", ro0); end
    vectors++; if (rs0 !== 1'b0)  begin miscompares++; $display("FAIL t1_resp: got %b want 0", rs0); end
  endtask

  task automatic test_write_read;
    step(S0, 32'h08, 1'b1, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'h5);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b1) begin miscompares++; $display("FAIL t2_wr_ready: got %b want 1", ro0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    step(S0, 32'h08, 1'b0, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'h5) begin miscompares++; $display("FAIL t2_rdata: got %h want 5", rd0); end
    vectors++; if (ro0 !== 1'b1)  begin miscompares++; $display("FAIL t2_rd_ready: got %b want 1", ro0); end
  endtask

  task automatic test_forwarding;
    step(S0, 32'h0C, 1'b1, NS, WD, 32'h0);
    step(S0, 32'h0C, 1'b0, NS, WD, 32'hA);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b1) begin miscompares++; $display("FAIL t3_wr_ready: got %b want 1", ro0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'hA) begin miscompares++; $display("FAIL t3_fwd_rdata: got %h want a", rd0); end
  endtask

  task automatic test_back_to_back;
    step(S0, 32'h00, 1'b1, NS, WD, 32'h0);
    step(S0, 32'h04, 1'b1, NS, WD, 32'h11);
    step(S0, 32'h00, 1'b0, NS, WD, 32'h22);
    step(S0, 32'h04, 1'b0, NS, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'h11) begin miscompares++; $display("FAIL b2b_rd0: got %h want 11", rd0); end
    vectors++; if (ro0 !== 1'b1)   begin miscompares++; $display("FAIL b2b_ready: got %b want 1", ro0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'h22) begin miscompares++; $display("FAIL b2b_rd1: got %h want 22", rd0); end
  endtask

  task automatic test_wait_states;
    step(S2, 32'h08, 1'b1, NS, WD, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(S2, 32'h00, 1'b0, ID, WD, 32'h5);
      @(negedge Hclk);
      vectors++;
      if (ro2 !== (i == 2)) begin miscompares++; $display("FAIL t4_wr_ready[%0d]: got %b want %b", i, ro2, (i == 2)); end
    end
    step(S2, 32'h00, 1'b0, ID, WD, 32'h0);
    step(S2, 32'h08, 1'b0, NS, WD, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(S2, 32'h00, 1'b0, ID, WD, 32'h0);
      @(negedge Hclk);
      vectors++;
      if (ro2 !== (i == 2)) begin miscompares++; $display("FAIL t4_rd_ready[%0d]: got %b want %b", i, ro2, (i == 2)); end
    end
    vectors++; if (rd2 !== 32'h5) begin miscompares++; $display("FAIL t4_rdata: got %h want 5", rd2); end
    vectors++; if (rs2 !== 1'b0)  begin miscompares++; $display("FAIL t4_resp: got %b want 0", rs2); end
  endtask

  task automatic test_error;
    // out-of-range write (0x40 aliases index 0 if decoded wrongly)
    step(S0, 32'h40, 1'b1, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'hDEAD);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b0) begin miscompares++; $display("FAIL t5a_err1_ready: got %b want 0", ro0); end
    vectors++; if (rs0 !== 1'b1) begin miscompares++; $display("FAIL t5a_err1_resp: got %b want 1", rs0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'hDEAD);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b1) begin miscompares++; $display("FAIL t5a_err2_ready: got %b want 1", ro0); end
    vectors++; if (rs0 !== 1'b1) begin miscompares++; $display("FAIL t5a_err2_resp: got %b want 1", rs0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rs0 !== 1'b0) begin miscompares++; $display("FAIL t5a_after_resp: got %b want 0", rs0); end
    // misaligned write, with a read pipelined into the ERR2 cycle
    step(S0, 32'h02, 1'b1, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'hBEEF);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b0) begin miscompares++; $display("FAIL t5b_err1_ready: got %b want 0", ro0); end
    vectors++; if (rs0 !== 1'b1) begin miscompares++; $display("FAIL t5b_err1_resp: got %b want 1", rs0); end
    step(S0, 32'h00, 1'b0, NS, WD, 32'hBEEF);
    @(negedge Hclk);
    vectors++; if (ro0 !== 1'b1) begin miscompares++; $display("FAIL t5b_err2_ready: got %b want 1", ro0); end
    vectors++; if (rs0 !== 1'b1) begin miscompares++; $display("FAIL t5b_err2_resp: got %b want 1", rs0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rs0 !== 1'b0)   begin miscompares++; $display("FAIL t5b_rd_resp: got %b want 0", rs0); end
    vectors++; if (rd0 !== 32'h11) begin miscompares++; $display("FAIL t5b_mem0: got %h want 11", rd0); end
    // wrong Hsize write to 0x04
    step(S0, 32'h04, 1'b1, NS, 3'b001, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'h33);
    @(negedge Hclk);
    vectors++; if (rs0 !== 1'b1) begin miscompares++; $display("FAIL t5c_size_resp: got %b want 1", rs0); end
    step(S0, 32'h00, 1'b0, ID, WD, 32'h33);
    step(S0, 32'h04, 1'b0, NS, WD, 32'h0);
    step(S0, 32'h00, 1'b0, ID, WD, 32'h0);
    @(negedge Hclk);
    vectors++; if (rd0 !== 32'h22) begin miscompares++; $display("FAIL t5c_mem1: got %h want 22", rd0); end
    vectors++; if (rs0 !== 1'b0)   begin miscompares++; $display("FAIL t5c_rd_resp: got %b want 0", rs0); end
  endtask

  task automatic test_reset_mid_wait;
    // first a normal W=3 write/read of 0x14 = 9
    step(S3, 32'h14, 1'b1, NS, WD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(S3, 32'h00, 1'b0, ID, WD, 32'h9);
      @(negedge Hclk);
      vectors++;
      if (ro3 !== (i == 3)) begin miscompares++; $display("FAIL t6_wr_ready[%0d]: got %b want %b", i, ro3, (i == 3)); end
    end
    step(S3, 32'h14, 1'b0, NS, WD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(S3, 32'h00, 1'b0, ID, WD, 32'h0);
      @(negedge Hclk);
    end
    vectors++; if (rd3 !== 32'h9) begin miscompares++; $display("FAIL t6_rd14: got %h want 9", rd3); end
    // write 0x10 = 7, reset during its wait states
    step(S3, 32'h10, 1'b1, NS, WD, 32'h0);
    step(S3, 32'h00, 1'b0, ID, WD, 32'h7);
    @(negedge Hclk);
    vectors++; if (ro3 !== 1'b0) begin miscompares++; $display("FAIL t6_wait_ready: got %b want 0", ro3); end
    #2 Hresetn = 1'b0;
    #1;
    vectors++; if (ro3 !== 1'b1)  begin miscompares++; $display("FAIL t6_rst_ready: got %b want 1", ro3); end
    vectors++; if (rs3 !== 1'b0)  begin miscompares++; $display("FAIL t6_rst_resp: got %b want 0", rs3); end
    vectors++; if (rd3 !== 32'h0) begin miscompares++; $display("FAIL t6_rst_rdata: got %h want 0", rd3); end
    @(negedge Hclk);
    Hresetn = 1'b1;
    step(S3, 32'h00, 1'b0, ID, WD, 32'h0);
    step(S3, 32'h10, 1'b0, NS, WD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(S3, 32'h00, 1'b0, ID, WD, 32'h0);
      @(negedge Hclk);
      vectors++;
      if (ro3 !== (i == 3)) begin miscompares++; $display("FAIL t6_rd_ready[%0d]: got %b want %b", i, ro3, (i == 3)); end
    end
    vectors++; if (rd3 !== 32'h0) begin miscompares++; $display("FAIL t6_rd10: got %h want 0", rd3); end
    step(S3, 32'h14, 1'b0, NS, WD, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(S3, 32'h00, 1'b0, ID, WD, 32'h0);
      @(negedge Hclk);
    end
    vectors++; if (rd3 !== 32'h0) begin miscompares++; $display("FAIL t6_rd14_cleared: got %h want 0", rd3); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_forwarding;
    test_back_to_back;
    test_wait_states;
    test_error;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
